mem_read_arbi_nch: RTL
======================

# mem_read_arbi_nch

Parametrised N-channel read arbiter between the DDR read clients and the single DDR read-command port of the memory controller wrapper. Replaces the fixed four-channel polling scheme: eligible channels are granted in one cycle using round-robin order, length and address are latched at grant, and read data is returned only to the granted channel. A per-burst beat counter and a watchdog detect short bursts and hung bursts.

## Interface
- CH_NUM, 4: number of client channels, 1..16
- MEM_DATA_BITS, 256: read data width
- ADDR_WIDTH, 30: DDR address width
- LEN_WIDTH, 8: burst length field width, in beats
- TIMEOUT_CYCLES, 8000: watchdog limit in ddr_clk_i cycles; used only with the watchdog compiled in

- ddr_clk_i  in  1  single clock for all logic
- ddr_rst_n_i  in  1  asynchronous active-low reset
- ch_rd_ddr_req  in  CH_NUM  per-channel level request, held until the channel's finish or timeout pulse
- ch_rd_ddr_len  in  CH_NUM*LEN_WIDTH  packed lengths; channel i at [i*LEN_WIDTH +: LEN_WIDTH]
- ch_rd_ddr_addr  in  CH_NUM*ADDR_WIDTH  packed start addresses, same packing
- ch_rd_ddr_data_valid  out  CH_NUM  one-hot per-channel data strobe
- ch_rd_ddr_data  out  MEM_DATA_BITS  read data, zero when no strobe is active
- ch_rd_ddr_finish  out  CH_NUM  one-cycle burst-complete pulse
- ch_rd_ddr_len_err  out  CH_NUM  one-cycle pulse coincident with finish when received beats differ from the granted length
- ch_rd_ddr_timeout  out  CH_NUM  one-cycle watchdog-abort pulse
- rd_ddr_req  out  1  command request to the controller
- rd_ddr_len  out  LEN_WIDTH  granted length
- rd_ddr_addr  out  ADDR_WIDTH  granted address
- rd_ddr_data_valid  in  1  controller data strobe
- rd_ddr_data  in  MEM_DATA_BITS  controller data
- rd_ddr_finish  in  1  controller burst-done
- arb_busy  out  1  high in every state other than ARB

## Operation
- Reset values: all outputs 0. State is ARB. Grant pointer is CH_NUM-1, so channel 0 has first priority. Beat counter and watchdog are 0.
- A channel is eligible when its req is 1 and its len is non-zero. Zero-length requests are never granted and never acknowledged.
- ARB: if any channel is eligible, grant the first eligible index after the pointer, searching upward with wrap, and go to LOAD. Otherwise stay in ARB.
- LOAD: register rd_ddr_len and rd_ddr_addr from the granted channel, set rd_ddr_req, clear the beat counter, and go to READ. Client len/addr changes after LOAD are ignored.
- READ:
  - rd_ddr_req clears on the edge after the first rd_ddr_data_valid.
  - Each rd_ddr_data_valid is forwarded to the granted channel's strobe with the data, and the beat counter increments, saturating at its maximum.
  - rd_ddr_finish is delayed through two registers. When the delayed copy is high, go to END.
- END: lasts one cycle.
  - Pulse ch_rd_ddr_finish[g].
  - Pulse ch_rd_ddr_len_err[g] if the beat count is not equal to rd_ddr_len.
  - Set the pointer to g and return to ARB.
- Beats arriving outside READ are dropped. They are not forwarded and not counted.
- rd_ddr_len and rd_ddr_addr hold their last value outside LOAD.
- Reset assertion mid-burst returns the block to its reset state immediately. No finish pulse is generated.

## Timing
- Eligible request seen in ARB at cycle t: LOAD at t+1, rd_ddr_req high from t+2.
- With CH_NUM requests always pending, the minimum arbitration overhead between bursts is 3 cycles: END, ARB, LOAD.
- Data-path latency from rd_ddr_data_valid to ch_rd_ddr_data_valid is 0 cycles (combinational mux gated by state and grant).
- Finish: rd_ddr_finish high at edge k gives END during cycle k+3, with ch_rd_ddr_finish high in that cycle.
- If rd_ddr_finish and the last data beat arrive in the same cycle, the beat is still delivered and counted.

## Configuration
- MEM_RD_ARBI_WATCHDOG_EN defined:
  - A 16-bit counter clears in ARB and increments in LOAD, READ and END.
  - When it reaches TIMEOUT_CYCLES in READ: pulse ch_rd_ddr_timeout[g], clear rd_ddr_req, set the pointer to g, and return to ARB. No finish or len_err pulse is generated.
- MEM_RD_ARBI_WATCHDOG_EN undefined:
  - No counter is built, and ch_rd_ddr_timeout is tied to 0.
  - READ waits for finish indefinitely.

## Test plan
- Reset, then ch0 req with len=4, addr=0x100: rd_ddr_addr=0x100 and rd_ddr_len=4; 4 beats appear only on ch_rd_ddr_data_valid[0]; a single ch_rd_ddr_finish[0] pulse; len_err stays 0.
- All four channels request continuously with len=2: grants follow the order 0,1,2,3,0. No channel is granted twice before the others are served.
- ch2 req with len=0 while ch3 has len=1: ch2 is never granted; ch3 completes normally.
- ch1 with len=8, controller returns 6 beats then finish: ch_rd_ddr_finish[1] and ch_rd_ddr_len_err[1] pulse in the same cycle.
- With the watchdog compiled in and TIMEOUT_CYCLES=50, ch0 granted but no data or finish returned: ch_rd_ddr_timeout[0] pulses about 50 cycles after LOAD, rd_ddr_req drops, and ch1 is granted next. With the watchdog compiled out, the block stays in READ.
- Drive ddr_rst_n_i low mid-burst after 3 of 8 beats: all outputs go to 0 immediately. After release, channel 0 is granted first.

Source files
------------

// File: rtl/mem_read_arbi_nch_if.sv
// mem_read_arbi_nch_if: DDR read-command port between the N-channel read
// arbiter (master) and the memory controller wrapper (slave).
interface mem_read_arbi_nch_if #(
  parameter int MEM_DATA_BITS = 256,
  parameter int ADDR_WIDTH    = 30,
  parameter int LEN_WIDTH     = 8
);
  logic                     rd_ddr_req;
  logic [LEN_WIDTH-1:0]     rd_ddr_len;
  logic [ADDR_WIDTH-1:0]    rd_ddr_addr;
  logic                     rd_ddr_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_ddr_data;
  logic                     rd_ddr_finish;

  modport master (
    output rd_ddr_req, rd_ddr_len, rd_ddr_addr,
    input  rd_ddr_data_valid, rd_ddr_data, rd_ddr_finish
  );

  modport slave (
    input  rd_ddr_req, rd_ddr_len, rd_ddr_addr,
    output rd_ddr_data_valid, rd_ddr_data, rd_ddr_finish
  );
endinterface

// File: rtl/mem_read_arbi_nch.sv
// mem_read_arbi_nch: round-robin arbiter that shares the single DDR read-command
// port among CH_NUM clients. Length/address are captured at grant, read data is
// steered only to the granted channel, and short bursts are flagged by len_err.
// Optional feature macro: MEM_RD_ARBI_WATCHDOG_EN adds a hung-burst watchdog.
module mem_read_arbi_nch #(
  parameter int CH_NUM         = 4,
  parameter int MEM_DATA_BITS  = 256,
  parameter int ADDR_WIDTH     = 30,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                         ddr_clk_i,
  input  logic                         ddr_rst_n_i,
  input  logic [CH_NUM-1:0]            ch_rd_ddr_req,
  input  logic [CH_NUM*LEN_WIDTH-1:0]  ch_rd_ddr_len,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_rd_ddr_addr,
  output logic [CH_NUM-1:0]            ch_rd_ddr_data_valid,
  output logic [MEM_DATA_BITS-1:0]     ch_rd_ddr_data,
  output logic [CH_NUM-1:0]            ch_rd_ddr_finish,
  output logic [CH_NUM-1:0]            ch_rd_ddr_len_err,
  output logic [CH_NUM-1:0]            ch_rd_ddr_timeout,
  mem_read_arbi_nch_if.master          ddr,
  output logic                         arb_busy
);

  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
    $error("mem_read_arbi_nch: CH_NUM must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_read_arbi_nch: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  typedef enum logic [1:0] {ARB, LOAD, READ, END} arb_state_e;

  arb_state_e              state, state_nxt;
  logic [IDX_W-1:0]        grant_ptr;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        next_grant;
  logic                    grant_found;
  logic [IDX_W:0]          cand;
  logic [CH_NUM-1:0]       eligible;
  logic [CH_NUM-1:0]       grant_onehot;
  logic [LEN_WIDTH-1:0]    ch_len  [CH_NUM];
  logic [ADDR_WIDTH-1:0]   ch_addr [CH_NUM];
  logic                    rd_req_q;
  logic [LEN_WIDTH-1:0]    rd_len_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [LEN_WIDTH-1:0]    beat_cnt;
  logic                    fin_d1, fin_d2;
  logic                    timeout_hit;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_unpack
    assign ch_len[i]   = ch_rd_ddr_len[i*LEN_WIDTH +: LEN_WIDTH];
    assign ch_addr[i]  = ch_rd_ddr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign eligible[i] = ch_rd_ddr_req[i] & (|ch_rd_ddr_len[i*LEN_WIDTH +: LEN_WIDTH]);
  end

  assign grant_onehot    = CH_NUM'(1) << grant_idx;
  assign ddr.rd_ddr_req  = rd_req_q;
  assign ddr.rd_ddr_len  = rd_len_q;
  assign ddr.rd_ddr_addr = rd_addr_q;

`ifdef MEM_RD_ARBI_WATCHDOG_EN
  logic [15:0] wd_cnt;

  // Watchdog counts every non-ARB cycle so a silent controller cannot hang a channel
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i)          wd_cnt <= '0;
    else if (state == ARB)     wd_cnt <= '0;
    else if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
  end

  assign timeout_hit = (state == READ) && !fin_d2 && (wd_cnt == 16'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // Round-robin search: first eligible channel strictly after the pointer, with wrap
  always_comb begin
    grant_found = 1'b0;
    next_grant  = grant_ptr;
    cand        = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      cand = {1'b0, grant_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(CH_NUM)) cand = cand - (IDX_W+1)'(CH_NUM);
      if (!grant_found && eligible[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        next_grant  = cand[IDX_W-1:0];
      end
    end
  end

  // FSM state register
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) state <= ARB;
    else              state <= state_nxt;
  end

  // FSM next-state logic; a completed finish wins over a simultaneous watchdog expiry
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (grant_found) state_nxt = LOAD;
      LOAD:    state_nxt = READ;
      READ: begin
        if (fin_d2)           state_nxt = END;
        else if (timeout_hit) state_nxt = ARB;
      end
      END:     state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // FSM outputs: data steering is combinational so beats reach the client with zero latency
  always_comb begin
    ch_rd_ddr_data_valid = '0;
    ch_rd_ddr_data       = '0;
    ch_rd_ddr_finish     = '0;
    ch_rd_ddr_len_err    = '0;
    ch_rd_ddr_timeout    = '0;
    arb_busy             = (state != ARB);
    if (state == READ && ddr.rd_ddr_data_valid) begin
      ch_rd_ddr_data_valid = grant_onehot;
      ch_rd_ddr_data       = ddr.rd_ddr_data;
    end
    if (state == END) begin
      ch_rd_ddr_finish = grant_onehot;
      if (beat_cnt != rd_len_q) ch_rd_ddr_len_err = grant_onehot;
    end
    if (timeout_hit) ch_rd_ddr_timeout = grant_onehot;
  end

  // Grant index is captured at arbitration; the pointer moves to it once the burst ends
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      grant_ptr <= IDX_W'(CH_NUM - 1);
      grant_idx <= '0;
    end else begin
      if (state == ARB && grant_found) grant_idx <= next_grant;
      if (state == END || timeout_hit) grant_ptr <= grant_idx;
    end
  end

  // Command registers: loaded once per burst, request dropped after the first beat or on exit
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      rd_req_q  <= 1'b0;
      rd_len_q  <= '0;
      rd_addr_q <= '0;
    end else if (state == LOAD) begin
      rd_req_q  <= 1'b1;
      rd_len_q  <= ch_len[grant_idx];
      rd_addr_q <= ch_addr[grant_idx];
    end else if (state == READ && (ddr.rd_ddr_data_valid || state_nxt != READ)) begin
      rd_req_q  <= 1'b0;
    end
  end

  // Beat counter only advances on beats accepted in READ, saturating at full scale
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i)
      beat_cnt <= '0;
    else if (state == LOAD)
      beat_cnt <= '0;
    else if (state == READ && ddr.rd_ddr_data_valid && beat_cnt != '1)
      beat_cnt <= beat_cnt + LEN_WIDTH'(1);
  end

  // Two-stage finish delay lets trailing beats land before the burst is closed
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      fin_d1 <= 1'b0;
      fin_d2 <= 1'b0;
    end else begin
      fin_d1 <= ddr.rd_ddr_finish;
      fin_d2 <= fin_d1;
    end
  end

endmodule
